// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage in front of the instruction port of a Harvard
// memory. Fetches sequentially from RESET_VECTOR, buffers {instruction, PC}
// pairs in a small prefetch FIFO and hands them to decode over valid/ready.
// A redirect flushes the FIFO and any fetch still in flight.
//
// Optional build macro: FETCH_PERF_EN adds saturating performance counters.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   ip_address, read_ip      instruction port request (read_ip combinational)
//   ip_data, stall           instruction port response / busy
//   instr_out, pc_out        FIFO head instruction and its address
//   instr_valid, instr_ready decode handshake
//   redirect, redirect_pc    fetch redirect (bits [1:0] of the target ignored)
//   perf_stall_cycles        (FETCH_PERF_EN) cycles with read_ip && stall
//   perf_redirects           (FETCH_PERF_EN) redirect edges
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] ip_address,
   output logic        read_ip,
   input  logic [31:0] ip_data,
   input  logic        stall,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_redirects
`endif
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   // Fetch control state
   logic [0:0]       state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic             inflight_q, inflight_d;
   logic [31:0]      inflight_pc_q, inflight_pc_d;

   // Prefetch FIFO bookkeeping
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] remain;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]      mem_instr [FIFO_DEPTH];
   logic [31:0]      mem_pc    [FIFO_DEPTH];

   // Next head outputs
   logic             valid_d;
   logic [31:0]      instr_d;
   logic [31:0]      pc_d;

   logic             room;
   logic             accept;
   logic             push;
   logic             pop;
   logic [31:0]      redirect_target;

   // Room is judged on the occupancy before this cycle's pop, counting the
   // fetch already in flight so its response always has a slot.
   assign room    = (32'(count_q) + 32'(inflight_q)) < FIFO_DEPTH;
   assign read_ip = rst && (state_q == ST_RUN) && !redirect && room;
   assign accept  = read_ip && !stall;

   // Responses are dropped while flushing or when a redirect lands on them.
   assign push    = inflight_q && (state_q == ST_RUN) && !redirect;
   assign pop     = (count_q != '0) && instr_ready && !redirect;

   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
   assign ip_address      = fetch_pc_q;

   // Next-state and next-output logic
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      remain        = count_q - CNT_W'(pop);
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      valid_d       = instr_valid;
      instr_d       = instr_out;
      pc_d          = pc_out;

      case (state_q)
         ST_RUN: begin
            if (redirect && inflight_q) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      if (redirect) begin
         // Redirect wins over push, pop and issue; the head registers keep
         // their last value since the FIFO is now empty.
         fetch_pc_d = redirect_target;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         valid_d    = 1'b0;
      end else begin
         // A request lives in flight for exactly one cycle.
         inflight_d = accept;
         if (accept) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_pc_d = fetch_pc_q;
         end
         count_d  = remain + CNT_W'(push);
         rd_ptr_d = rd_ptr_q + PTR_W'(pop);
         wr_ptr_d = wr_ptr_q + PTR_W'(push);
         valid_d  = (count_d != '0);
         // New head: oldest surviving entry, else the entry pushed this edge.
         if (remain != '0) begin
            instr_d = mem_instr[rd_ptr_d];
            pc_d    = mem_pc[rd_ptr_d];
         end else if (push) begin
            instr_d = ip_data;
            pc_d    = inflight_pc_q;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_RUN;
         fetch_pc_q    <= RESET_VECTOR;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         instr_valid   <= 1'b0;
         instr_out     <= '0;
         pc_out        <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         instr_valid   <= valid_d;
         instr_out     <= instr_d;
         pc_out        <= pc_d;
      end
   end

   // FIFO storage; occupancy is tracked by the pointers, so no reset needed
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr_q] <= ip_data;
         mem_pc[wr_ptr_q]    <= inflight_pc_q;
      end
   end

`ifdef FETCH_PERF_EN
   // Saturating performance counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cycles <= '0;
         perf_redirects    <= '0;
      end else begin
         if (read_ip && stall && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         end
         if (redirect && (perf_redirects != 32'hFFFF_FFFF)) begin
            perf_redirects <= perf_redirects + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed scenarios followed by a randomized phase. The reference model is
// transaction level: consumed PCs must follow strictly sequentially from the
// reset vector or from the last redirect target, and each instruction must be
// the memory word stored at its PC.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] RV = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ip_address;
   logic        read_ip;
   logic [31:0] ip_data;
   logic        stall;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_redirects;
   logic [31:0] m_stall;
   logic [31:0] m_redir;
`endif

   int          checks = 0;
   int          errors = 0;
   int          n_pop  = 0;
   logic [31:0] exp_pc;
   logic [31:0] held;

   fetch_unit #(
      .RESET_VECTOR(RV),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ip_address (ip_address),
      .read_ip    (read_ip),
      .ip_data    (ip_data),
      .stall      (stall),
      .instr_out  (instr_out),
      .pc_out     (pc_out),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .redirect   (redirect),
      .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
      ,
      .perf_stall_cycles(perf_stall_cycles),
      .perf_redirects   (perf_redirects)
`endif
   );

   always #5 clk = ~clk;

   // Memory contents: 0x11111111, 0x22222222, ... from the reset vector
   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [31:0] k;
      k = ((a - RV) >> 2) + 32'd1;
      return k * 32'h1111_1111;
   endfunction

   // Instruction memory: answers an accepted request on the next edge,
   // otherwise presents garbage so a wrongly captured word is visible.
   always @(posedge clk) begin
      ip_data <= (read_ip && !stall) ? word_at(ip_address) : 32'hDEAD_BEEF;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One clock cycle: scoreboard the handshake before the edge, then return
   // 1 time unit after the edge with registered outputs settled.
   task automatic step();
      logic        hold;
      logic [31:0] addr;
      @(negedge clk);
      if (instr_valid && instr_ready && !redirect) begin
         chk("sb_pc", pc_out, exp_pc);
         chk("sb_instr", instr_out, word_at(exp_pc));
         exp_pc = exp_pc + 32'd4;
         n_pop++;
      end
      if (redirect) begin
         chk1("redirect_read_ip", read_ip, 1'b0);
         exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end
      hold = read_ip && stall && !redirect;
      addr = ip_address;
`ifdef FETCH_PERF_EN
      if (read_ip && stall && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
      if (redirect && (m_redir != 32'hFFFF_FFFF)) m_redir = m_redir + 32'd1;
`endif
      @(posedge clk);
      #1;
      if (hold) chk("stall_hold_addr", ip_address, addr);
   endtask

   // Assert reset between edges, check reset values, release after one edge
   task automatic do_reset();
      rst = 1'b0;
      #1;
      chk1("rst_read_ip", read_ip, 1'b0);
      chk("rst_ip_address", ip_address, RV);
      chk1("rst_instr_valid", instr_valid, 1'b0);
      chk("rst_instr_out", instr_out, 32'h0);
      chk("rst_pc_out", pc_out, 32'h0);
`ifdef FETCH_PERF_EN
      chk("rst_perf_stall", perf_stall_cycles, 32'h0);
      chk("rst_perf_redir", perf_redirects, 32'h0);
      m_stall = '0;
      m_redir = '0;
`endif
      exp_pc = RV;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      rst         = 1'b1;
      stall       = 1'b0;
      instr_ready = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      exp_pc      = RV;
      #2;

      // Streaming from reset: valid two edges after release
      do_reset();
      step();
      chk1("lat_edge1_valid", instr_valid, 1'b0);
      step();
      chk1("lat_edge2_valid", instr_valid, 1'b1);
      chk("lat_first_pc", pc_out, RV);
      chk("lat_first_instr", instr_out, 32'h1111_1111);
      step();
      chk("stream_second_pc", pc_out, RV + 32'd4);
      chk("stream_second_instr", instr_out, 32'h2222_2222);
      repeat (5) step();

      // Decode never ready: FIFO fills with exactly four entries
      instr_ready = 1'b0;
      do_reset();
      repeat (10) step();
      chk1("full_valid", instr_valid, 1'b1);
      chk("full_head_pc", pc_out, RV);
      chk1("full_read_ip", read_ip, 1'b0);
      chk("full_ip_address", ip_address, RV + 32'd16);
      instr_ready = 1'b1;
      repeat (4) step();
      chk1("drain_valid", instr_valid, 1'b1);
      chk("drain_pc", pc_out, RV + 32'd16);
      repeat (4) step();

      // Memory stall for three cycles mid-stream
      stall = 1'b1;
      held  = ip_address;
      repeat (3) begin
         step();
         chk("stall_addr", ip_address, held);
         chk1("stall_read_ip", read_ip, 1'b1);
      end
      stall = 1'b0;
      repeat (6) step();

      // Redirect while a fetch is in flight: one flush cycle
      redirect    = 1'b1;
      redirect_pc = 32'hBFC0_0103;
      step();
      redirect = 1'b0;
      #1;
      chk1("flush_valid", instr_valid, 1'b0);
      chk1("flush_read_ip", read_ip, 1'b0);
      chk("flush_ip_address", ip_address, 32'hBFC0_0100);
      step();
      chk1("post_flush_read_ip", read_ip, 1'b1);
      step();
      chk1("post_flush_valid", instr_valid, 1'b0);
      step();
      chk1("redir_valid", instr_valid, 1'b1);
      chk("redir_pc", pc_out, 32'hBFC0_0100);
      chk("redir_instr", instr_out, word_at(32'hBFC0_0100));
      repeat (3) step();

      // Address wrap at the top of the address space
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      step();
      redirect = 1'b0;
      repeat (3) step();
      chk("wrap_pc0", pc_out, 32'hFFFF_FFF8);
      step();
      chk("wrap_pc1", pc_out, 32'hFFFF_FFFC);
      step();
      chk("wrap_pc2", pc_out, 32'h0000_0000);
      chk("wrap_instr2", instr_out, word_at(32'h0000_0000));

      // Randomized traffic against the sequential-PC scoreboard
      repeat (400) begin
         stall       = (($urandom % 4) == 0);
         instr_ready = (($urandom % 3) != 0);
         redirect    = (($urandom % 20) == 0);
         redirect_pc = $urandom;
         step();
      end
      redirect = 1'b0;
      stall    = 1'b0;

      // Fill the FIFO, then reset asynchronously between edges
      instr_ready = 1'b0;
      repeat (8) step();
      chk1("prerst_valid", instr_valid, 1'b1);
      chk1("prerst_read_ip", read_ip, 1'b0);
`ifdef FETCH_PERF_EN
      chk("perf_stall_cycles", perf_stall_cycles, m_stall);
      chk("perf_redirects", perf_redirects, m_redir);
`endif
      #3;
      instr_ready = 1'b1;
      do_reset();
      step();
      step();
      chk1("restart_valid", instr_valid, 1'b1);
      chk("restart_pc", pc_out, RV);
      chk("restart_instr", instr_out, 32'h1111_1111);
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
